// File: rtl/keyboard_voice_ctrl.sv
// keyboard_voice_ctrl: monophonic keyboard front-end.
// Debounces N keys, picks one voice with last-note priority (falling back
// to a still-held key), applies an octave shift to the key's half-period
// divisor and drives an internal square-wave tone generator.
module keyboard_voice_ctrl #(
    parameter int CLK_HZ      = 25_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int N_KEYS      = 8,
    parameter int DIV_W       = 16,
    parameter logic [N_KEYS*DIV_W-1:0] DIV_TABLE = {
        16'd11945, 16'd12655, 16'd14205, 16'd15944,
        16'd17896, 16'd18960, 16'd21282, 16'd23889
    },
    parameter int KEY_W = $clog2(N_KEYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] btn_raw,
    input  logic [1:0]        octave,
    output logic              pwm_out,
    output logic              gate,
    output logic [KEY_W-1:0]  active_key,
    output logic [N_KEYS-1:0] btn_stable,
    output logic [31:0]       note_counter,
    output logic [DIV_W-1:0]  note_div_out
);

    localparam int CNT_RAW = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int CNT_MAX = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam int DB_W    = $clog2(CNT_MAX + 1);

    logic [N_KEYS-1:0] sync0;
    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] stable_d;
    logic [DB_W-1:0]   db_cnt [N_KEYS];
    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] rel;
    logic [DIV_W-1:0]  table_div;
    logic [DIV_W-1:0]  shifted_div;
    logic [DIV_W-1:0]  eff_div;
    logic [DIV_W-1:0]  tone_cnt;

    // Lowest set bit of a key vector; zero when no bit is set.
    function automatic logic [KEY_W-1:0] lowest_key(input logic [N_KEYS-1:0] v);
        lowest_key = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (v[i]) lowest_key = KEY_W'(i);
        end
    endfunction

    // Two-flop synchroniser for the asynchronous key inputs, plus the
    // delayed copy of the debounced state used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0    <= '0;
            sync1    <= '0;
            stable_d <= '0;
        end else begin
            sync0    <= btn_raw;
            sync1    <= sync0;
            stable_d <= btn_stable;
        end
    end

    // Per-key debounce: the stable bit only follows after CNT_MAX+1
    // consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_stable <= '0;
            for (int i = 0; i < N_KEYS; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (sync1[i] == btn_stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(CNT_MAX)) begin
                    btn_stable[i] <= sync1[i];
                    db_cnt[i]     <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = btn_stable & ~stable_d;
    assign rel   = ~btn_stable & stable_d;

    // Voice allocation: a new press always wins; losing the sounding key
    // falls back to the lowest held key or silences the gate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_key <= '0;
            gate       <= 1'b0;
        end else if (|press) begin
            active_key <= lowest_key(press);
            gate       <= 1'b1;
        end else if (rel[active_key]) begin
            if (|btn_stable) begin
                active_key <= lowest_key(btn_stable);
            end else begin
                gate <= 1'b0;
            end
        end
    end

    // Saturating count of cycles that contain at least one new press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_counter <= '0;
        end else if ((|press) && (note_counter != 32'hFFFF_FFFF)) begin
            note_counter <= note_counter + 32'd1;
        end
    end

    assign table_div   = DIV_TABLE[int'(active_key) * DIV_W +: DIV_W];
    assign shifted_div = table_div >> octave;
    assign eff_div     = (shifted_div < DIV_W'(2)) ? DIV_W'(2) : shifted_div;

    // Registered divisor in use; zero whenever no note is gated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_div_out <= '0;
        end else begin
            note_div_out <= gate ? eff_div : '0;
        end
    end

    // Tone generator: toggle every note_div_out cycles; the >= compare
    // keeps a shrinking divisor from stretching the current half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt <= '0;
            pwm_out  <= 1'b0;
        end else if (note_div_out == '0) begin
            tone_cnt <= '0;
            pwm_out  <= 1'b0;
        end else if (tone_cnt >= note_div_out - 1'b1) begin
            tone_cnt <= '0;
            pwm_out  <= ~pwm_out;
        end else begin
            tone_cnt <= tone_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_keyboard_voice_ctrl.sv
// Testbench for keyboard_voice_ctrl: vector table, hand-written timing
// sequences and randomized key patterns against an event-level model.
module tb_keyboard_voice_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [1:0] octave;
    logic       pwm_out;
    logic       gate;
    logic [1:0] active_key;
    logic [3:0] btn_stable;
    logic [31:0] note_counter;
    logic [7:0] note_div_out;

    int testsRun;
    int testsFailed;

    keyboard_voice_ctrl #(
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (4),
        .N_KEYS      (4),
        .DIV_W       (8),
        .DIV_TABLE   ({8'd4, 8'd6, 8'd8, 8'd10})
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .octave       (octave),
        .pwm_out      (pwm_out),
        .gate         (gate),
        .active_key   (active_key),
        .btn_stable   (btn_stable),
        .note_counter (note_counter),
        .note_div_out (note_div_out)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  raw;
        logic [1:0]  oct;
        logic        gate;
        logic [1:0]  ak;
        logic [7:0]  div;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs [13];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic applyStimulus(input logic [3:0] raw, input logic [1:0] oct);
        @(negedge clk);
        btn_raw = raw;
        octave  = oct;
        repeat (12) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        btn_raw = '0;
        octave  = '0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic waitDiv(input logic wantNonzero, input string name);
        int n;
        n = 0;
        while (((note_div_out != 0) != wantNonzero) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) timeoutFail(name);
    endtask

    task automatic measureHalf(output int n);
        logic start;
        start = pwm_out;
        n = 0;
        while (pwm_out == start && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    function automatic logic [1:0] modelLowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    function automatic logic [7:0] modelDiv(input logic g, input logic [1:0] k, input logic [1:0] o);
        int halfPeriods [4];
        int e;
        halfPeriods = '{10, 8, 6, 4};
        if (!g) return 8'd0;
        e = halfPeriods[k] / (1 << o);
        if (e < 2) e = 2;
        return 8'(e);
    endfunction

    // Watchdog so the bench can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic sawStable;
        logic [3:0] mHeld;
        logic [3:0] newRaw;
        logic [3:0] mPress;
        logic [3:0] mRel;
        logic [1:0] newOct;
        logic       mGate;
        logic [1:0] mAk;
        logic [31:0] mCnt;

        testsRun    = 0;
        testsFailed = 0;

        vecs[0]  = '{4'b0001, 2'd0, 1'b1, 2'd0, 8'd10, 32'd1};
        vecs[1]  = '{4'b0101, 2'd0, 1'b1, 2'd2, 8'd6,  32'd2};
        vecs[2]  = '{4'b0001, 2'd0, 1'b1, 2'd0, 8'd10, 32'd2};
        vecs[3]  = '{4'b0000, 2'd0, 1'b0, 2'd0, 8'd0,  32'd2};
        vecs[4]  = '{4'b1010, 2'd0, 1'b1, 2'd1, 8'd8,  32'd3};
        vecs[5]  = '{4'b1000, 2'd0, 1'b1, 2'd3, 8'd4,  32'd3};
        vecs[6]  = '{4'b1000, 2'd3, 1'b1, 2'd3, 8'd2,  32'd3};
        vecs[7]  = '{4'b1000, 2'd1, 1'b1, 2'd3, 8'd2,  32'd3};
        vecs[8]  = '{4'b1000, 2'd2, 1'b1, 2'd3, 8'd2,  32'd3};
        vecs[9]  = '{4'b1001, 2'd0, 1'b1, 2'd0, 8'd10, 32'd4};
        vecs[10] = '{4'b0001, 2'd0, 1'b1, 2'd0, 8'd10, 32'd4};
        vecs[11] = '{4'b0011, 2'd1, 1'b1, 2'd1, 8'd4,  32'd5};
        vecs[12] = '{4'b0000, 2'd1, 1'b0, 2'd1, 8'd0,  32'd5};

        // Asynchronous reset state, checked before any clock edge.
        rst_n   = 1'b1;
        btn_raw = '0;
        octave  = '0;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_pwm", 32'(pwm_out), 32'd0);
        checkOutput("rst_gate", 32'(gate), 32'd0);
        checkOutput("rst_active_key", 32'(active_key), 32'd0);
        checkOutput("rst_btn_stable", 32'(btn_stable), 32'd0);
        checkOutput("rst_note_counter", note_counter, 32'd0);
        checkOutput("rst_note_div", 32'(note_div_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: held-key patterns applied in sequence.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].raw, vecs[i].oct);
            checkOutput($sformatf("vec%0d_stable", i), 32'(btn_stable), 32'(vecs[i].raw));
            checkOutput($sformatf("vec%0d_gate", i), 32'(gate), 32'(vecs[i].gate));
            checkOutput($sformatf("vec%0d_active_key", i), 32'(active_key), 32'(vecs[i].ak));
            checkOutput($sformatf("vec%0d_div", i), 32'(note_div_out), 32'(vecs[i].div));
            checkOutput($sformatf("vec%0d_counter", i), note_counter, vecs[i].cnt);
        end

        // Debounce: 4-cycle glitch rejected, held key appears 7 cycles later.
        doReset();
        sawStable = 1'b0;
        btn_raw = 4'b0010;
        repeat (4) begin
            @(negedge clk);
            if (btn_stable != 0) sawStable = 1'b1;
        end
        btn_raw = 4'b0000;
        repeat (12) begin
            @(negedge clk);
            if (btn_stable != 0) sawStable = 1'b1;
        end
        checkOutput("deb_glitch", 32'(sawStable), 32'd0);
        btn_raw = 4'b0010;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 6) checkOutput("deb_edge6", 32'(btn_stable[1]), 32'd0);
            if (i == 7) checkOutput("deb_edge7", 32'(btn_stable[1]), 32'd1);
        end
        repeat (13) @(negedge clk);
        btn_raw = 4'b0000;

        // Single note: first rise and steady half-periods of 10 cycles.
        doReset();
        btn_raw = 4'b0001;
        waitDiv(1'b1, "single_wait_div");
        checkOutput("single_div", 32'(note_div_out), 32'd10);
        measureHalf(n);
        checkOutput("single_first_rise", 32'(n), 32'd10);
        measureHalf(n);
        checkOutput("single_high", 32'(n), 32'd10);
        measureHalf(n);
        checkOutput("single_low", 32'(n), 32'd10);
        checkOutput("single_counter", note_counter, 32'd1);

        // Gate off: pwm forced low one cycle after the divisor drops to 0.
        btn_raw = 4'b0000;
        waitDiv(1'b0, "gateoff_wait_div");
        @(negedge clk);
        checkOutput("gateoff_pwm", 32'(pwm_out), 32'd0);
        checkOutput("gateoff_gate", 32'(gate), 32'd0);
        checkOutput("gateoff_active_key", 32'(active_key), 32'd0);

        // Octave shift with clamp: 4-cycle tone period.
        doReset();
        applyStimulus(4'b1000, 2'd1);
        checkOutput("oct_div", 32'(note_div_out), 32'd2);
        measureHalf(n);
        measureHalf(n);
        checkOutput("oct_half_a", 32'(n), 32'd2);
        measureHalf(n);
        checkOutput("oct_half_b", 32'(n), 32'd2);

        // Saturating press counter.
        doReset();
        force dut.note_counter = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.note_counter;
        applyStimulus(4'b0001, 2'd0);
        checkOutput("sat_first", note_counter, 32'hFFFF_FFFF);
        applyStimulus(4'b0000, 2'd0);
        applyStimulus(4'b0010, 2'd0);
        checkOutput("sat_hold", note_counter, 32'hFFFF_FFFF);

        // Asynchronous reset mid-tone, then a held key re-detected.
        doReset();
        applyStimulus(4'b0100, 2'd0);
        n = 0;
        while (pwm_out != 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) timeoutFail("arst_wait_pwm");
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_pwm", 32'(pwm_out), 32'd0);
        checkOutput("arst_gate", 32'(gate), 32'd0);
        checkOutput("arst_active_key", 32'(active_key), 32'd0);
        checkOutput("arst_btn_stable", 32'(btn_stable), 32'd0);
        checkOutput("arst_counter", note_counter, 32'd0);
        checkOutput("arst_div", 32'(note_div_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("arst_repress_ak", 32'(active_key), 32'd2);
        checkOutput("arst_repress_cnt", note_counter, 32'd1);
        checkOutput("arst_repress_div", 32'(note_div_out), 32'd6);

        // Randomized key patterns against the event-level model.
        doReset();
        mHeld = '0;
        mGate = 1'b0;
        mAk   = '0;
        mCnt  = '0;
        for (int it = 0; it < 40; it++) begin
            newRaw = 4'($urandom_range(0, 15));
            newOct = 2'($urandom_range(0, 3));
            applyStimulus(newRaw, newOct);
            mPress = newRaw & ~mHeld;
            mRel   = mHeld & ~newRaw;
            if (mPress != 0) begin
                mAk   = modelLowest(mPress);
                mGate = 1'b1;
                mCnt  = mCnt + 1;
            end else if (mRel[mAk]) begin
                if (newRaw != 0) mAk = modelLowest(newRaw);
                else mGate = 1'b0;
            end
            mHeld = newRaw;
            checkOutput($sformatf("rnd%0d_stable", it), 32'(btn_stable), 32'(mHeld));
            checkOutput($sformatf("rnd%0d_gate", it), 32'(gate), 32'(mGate));
            checkOutput($sformatf("rnd%0d_active_key", it), 32'(active_key), 32'(mAk));
            checkOutput($sformatf("rnd%0d_div", it), 32'(note_div_out), 32'(modelDiv(mGate, mAk, newOct)));
            checkOutput($sformatf("rnd%0d_counter", it), note_counter, mCnt);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
